// File: rtl/johnson_seq_ctrl.sv
// Round-robin sequencing controller for a shared Johnson (twisted-ring) phase register.
// Latency: grant one cycle after a request in IDLE; a burst of S steps holds the grant S+1 cycles.
// Backpressure: none; requests are level-sampled only in IDLE, and bursts always run to completion.
module johnson_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int N_REQ = 2,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_srst,
  input  logic [N_REQ-1:0] i_req,
  input  logic [CNT_W-1:0] i_steps,
  output logic [N_REQ-1:0] o_gnt,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_q,
  output logic             o_phase_err
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               done_q, done_d;
  logic               perr_q, perr_d;

  logic [WIDTH-1:0]   q_step;
  logic [WIDTH-1:0]   q_trans;
  logic               q_legal;
  logic               win_vld;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   arb_idx;
  int                 arb_cand;

  // Johnson step and legality: a legal Johnson word has at most one 0/1 boundary between adjacent bits.
  always_comb begin
    q_step  = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
    q_trans = '0;
    for (int i = 0; i < WIDTH - 1; i++) begin
      q_trans[i] = q_q[i] ^ q_q[i+1];
    end
    q_legal = ((q_trans & (q_trans - 1'b1)) == '0);
  end

  // Round-robin search starting one past the last winner, wrapping modulo N_REQ.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    arb_cand = 0;
    arb_idx  = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      arb_cand = (int'(ptr_q) + i) % N_REQ;
      arb_idx  = PTR_W'(arb_cand);
      if (!win_vld && i_req[arb_idx]) begin
        win_vld = 1'b1;
        win_idx = arb_idx;
      end
    end
  end

  // State register plus datapath flops; reset abandons any burst silently.
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      ptr_q   <= PTR_W'(N_REQ - 1);
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      done_q  <= done_d;
      perr_q  <= perr_d;
    end
  end

  // Next-state: a zero-length burst goes straight to DONE; RUN ends on the edge where cnt is 1.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          state_d = (i_steps != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values; illegal-phase correction overrides a RUN step but the count still moves.
  always_comb begin
    q_d    = q_q;
    cnt_d  = cnt_q;
    gnt_d  = gnt_q;
    ptr_d  = ptr_q;
    done_d = 1'b0;
    perr_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          gnt_d = N_REQ'(1) << win_idx;
          ptr_d = win_idx;
          cnt_d = i_steps;
        end
      end
      ST_RUN: begin
        q_d   = q_step;
        cnt_d = cnt_q - 1'b1;
      end
      ST_DONE: gnt_d = '0;
      default: gnt_d = '0;
    endcase
    if (state_d == ST_DONE) begin
      done_d = 1'b1;
    end
    if (!q_legal) begin
      q_d    = '0;
      perr_d = 1'b1;
    end
  end

  // Outputs come straight from flops so pulses are glitch-free and one cycle wide.
  always_comb begin
    o_gnt       = gnt_q;
    o_busy      = |gnt_q;
    o_done      = done_q;
    o_q         = q_q;
    o_phase_err = perr_q;
  end

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Randomised scoreboard bench for johnson_seq_ctrl: stimulus pushes per-burst expectations,
// a negedge monitor pops them and checks grant, phase sequence and done timing.
// Model works on phase indices into the legal-state table, not on register bits.
module tb_johnson_seq_ctrl;

  localparam int WIDTH = 4;
  localparam int N_REQ = 2;
  localparam int CNT_W = 8;

  logic             clk;
  logic             srst;
  logic [N_REQ-1:0] i_req;
  logic [CNT_W-1:0] i_steps;
  logic [N_REQ-1:0] o_gnt;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_q;
  logic             o_phase_err;

  johnson_seq_ctrl #(.WIDTH(WIDTH), .N_REQ(N_REQ), .CNT_W(CNT_W)) dut (
    .i_clk      (clk),
    .i_srst     (srst),
    .i_req      (i_req),
    .i_steps    (i_steps),
    .o_gnt      (o_gnt),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_q        (o_q),
    .o_phase_err(o_phase_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N_REQ-1:0] gnt;
    int               steps;
    int               start;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] seq_tbl [8];
  int         total;
  int         bad;
  int         m_ptr;
  int         m_idx;
  bit         perr_test;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N_REQ-1:0] req);
    int c;
    for (int i = 1; i <= N_REQ; i++) begin
      c = (m_ptr + i) % N_REQ;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  function automatic void push_burst(input logic [N_REQ-1:0] req, input int s);
    exp_t e;
    int   w;
    w = pick(req);
    e.gnt   = N_REQ'(1) << w;
    e.steps = s;
    e.start = m_idx;
    sb.push_back(e);
    m_ptr = w;
    m_idx = (m_idx + s) % 8;
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    while (o_busy && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_wait", {31'd0, o_busy}, 32'd0);
  endtask

  task automatic burst(input logic [N_REQ-1:0] req, input int s);
    logic [31:0] sv;
    wait_idle();
    sv      = s;
    i_req   = req;
    i_steps = sv[CNT_W-1:0];
    push_burst(req, s);
    @(posedge clk); #1;
    i_req   = '0;
    i_steps = CNT_W'($urandom);
  endtask

  task automatic do_reset();
    srst = 1'b1;
    @(posedge clk); #1;
    srst  = 1'b0;
    m_ptr = N_REQ - 1;
    m_idx = 0;
  endtask

  // Monitor: per-cycle checks against the head-of-queue burst expectation.
  initial begin
    exp_t cur;
    bit   in_b;
    bit   after_done;
    bit   prev_srst;
    int   k;
    logic [WIDTH-1:0] prev_q;
    in_b       = 1'b0;
    after_done = 1'b0;
    prev_srst  = 1'b1;
    k          = 0;
    prev_q     = '0;
    cur        = '{gnt: '0, steps: 0, start: 0};
    forever begin
      @(negedge clk);
      if (srst) begin
        sb.delete();
        in_b       = 1'b0;
        after_done = 1'b0;
        prev_srst  = 1'b1;
        prev_q     = o_q;
      end else begin
        chk("busy_eq_or_gnt", {31'd0, o_busy}, {31'd0, |o_gnt});
        if (after_done) chk("gnt_release", {30'd0, o_gnt}, 32'd0);
        after_done = 1'b0;
        if (o_gnt != '0) begin
          if (!in_b) begin
            if (sb.size() == 0) begin
              chk("unexpected_gnt", {30'd0, o_gnt}, 32'd0);
            end else begin
              cur  = sb[0];
              in_b = 1'b1;
              k    = 0;
            end
          end
          if (in_b) begin
            chk("gnt_value", {30'd0, o_gnt}, {30'd0, cur.gnt});
            chk("q_seq", {28'd0, o_q},
                {28'd0, seq_tbl[(cur.start + ((k < cur.steps) ? k : cur.steps)) % 8]});
            chk("done_timing", {31'd0, o_done}, {31'd0, (k == cur.steps)});
            if (o_done || k > cur.steps) begin
              void'(sb.pop_front());
              in_b       = 1'b0;
              after_done = 1'b1;
            end
            k++;
          end
        end else begin
          chk("done_idle", {31'd0, o_done}, 32'd0);
          if (in_b) begin
            chk("burst_cut_short", 32'd1, 32'd0);
            void'(sb.pop_front());
            in_b = 1'b0;
          end
          if (!perr_test && !prev_srst) chk("q_hold_idle", {28'd0, o_q}, {28'd0, prev_q});
        end
        if (!perr_test) chk("perr_quiet", {31'd0, o_phase_err}, 32'd0);
        prev_q    = o_q;
        prev_srst = 1'b0;
      end
    end
  end

  // Stimulus.
  initial begin
    int cyc;
    int ndone;
    int s;
    logic [N_REQ-1:0] r;
    seq_tbl = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
    total     = 0;
    bad       = 0;
    perr_test = 1'b0;
    srst      = 1'b1;
    i_req     = '0;
    i_steps   = '0;
    m_ptr     = N_REQ - 1;
    m_idx     = 0;
    @(posedge clk); #1;
    do_reset();

    chk("rst_q", {28'd0, o_q}, 32'd0);
    chk("rst_gnt", {30'd0, o_gnt}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_done", {31'd0, o_done}, 32'd0);
    chk("rst_perr", {31'd0, o_phase_err}, 32'd0);

    // Basic 3-step burst from requester 0.
    burst(2'b01, 3);
    chk("first_gnt_latency", {30'd0, o_gnt}, 32'd1);

    // Held dual request: four alternating 2-step bursts with one idle cycle between.
    wait_idle();
    i_req   = 2'b11;
    i_steps = 8'd2;
    for (int j = 0; j < 4; j++) push_burst(2'b11, 2);
    cyc   = 0;
    ndone = 0;
    while (ndone < 4 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (o_done) begin
        ndone++;
        if (ndone == 4) i_req = '0;
      end
    end
    chk("rr_total_cycles", cyc, 32'd15);

    // Zero-length burst.
    burst(2'b10, 0);

    // Reset in the middle of a long burst, with cnt at 5.
    burst(2'b01, 20);
    repeat (15) begin
      @(posedge clk); #1;
    end
    srst = 1'b1;
    @(posedge clk); #1;
    srst  = 1'b0;
    m_ptr = N_REQ - 1;
    m_idx = 0;
    chk("midrst_q", {28'd0, o_q}, 32'd0);
    chk("midrst_gnt", {30'd0, o_gnt}, 32'd0);
    chk("midrst_done", {31'd0, o_done}, 32'd0);

    // Nine steps from 0000 with both requesting: requester 0 wins after reset.
    burst(2'b11, 9);
    chk("post_rst_winner", {30'd0, o_gnt}, 32'd1);
    wait_idle();
    chk("s9_end_q", {28'd0, o_q}, 32'd1);

    // Maximum-length burst.
    burst(2'b10, 255);
    wait_idle();

    // Illegal phase value injected while idle.
    @(posedge clk); #1;
    perr_test = 1'b1;
    force dut.q_q = 4'b0101;
    #1;
    release dut.q_q;
    @(posedge clk); #1;
    chk("perr_q_cleared", {28'd0, o_q}, 32'd0);
    chk("perr_pulse", {31'd0, o_phase_err}, 32'd1);
    @(posedge clk); #1;
    chk("perr_one_cycle", {31'd0, o_phase_err}, 32'd0);
    chk("perr_q_stays", {28'd0, o_q}, 32'd0);
    m_idx = 0;
    @(posedge clk); #1;
    perr_test = 1'b0;

    // Random bursts.
    for (int j = 0; j < 25; j++) begin
      r = N_REQ'($urandom_range(1, 3));
      if ($urandom_range(0, 9) == 0) s = $urandom_range(0, 255);
      else s = $urandom_range(0, 10);
      burst(r, s);
    end
    wait_idle();
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("sb_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
